// File: rtl/fractcam_pkg.sv
// Shared definitions for the fractured TCAM update path: size defaults,
// rule-writer FSM encoding, shadow rule record and the ternary hit test.
package fractcam_pkg;

    localparam int unsigned KW_SIZE_DEF = 5;
    localparam int unsigned RD_SIZE_DEF = 32;
    localparam int unsigned GROUP_SIZE  = 8;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One ternary rule: mask bit set = don't-care on that key bit.
    typedef struct packed {
        logic                   valid;
        logic [KW_SIZE_DEF-1:0] value;
        logic [KW_SIZE_DEF-1:0] mask;
    } rule_entry_t;

    // Rule matches address a when every cared-about bit agrees.
    function automatic logic rule_hit(input rule_entry_t e, input logic [KW_SIZE_DEF-1:0] a);
        return e.valid && (((a ^ e.value) & ~e.mask) == '0);
    endfunction

endpackage

// File: rtl/dblock_rule_eval.sv
// Combinational evaluation of one 8-rule group at a LUTRAM address.
// Ports:
//   entries  in  8 shadow rule records of the selected group
//   addr     in  LUTRAM address (key value being written)
//   rules_c  out bit k set when entry k matches addr
module dblock_rule_eval
    import fractcam_pkg::*;
(
    input  rule_entry_t [GROUP_SIZE-1:0] entries,
    input  logic [KW_SIZE_DEF-1:0]       addr,
    output logic [GROUP_SIZE-1:0]        rules_c
);

    always_comb begin
        rules_c = '0;
        for (int k = 0; k < int'(GROUP_SIZE); k++) begin
            rules_c[k] = rule_hit(entries[k], addr);
        end
    end

endmodule

// File: rtl/dblock_rule_writer.sv
// Update controller for the 32-rule x 5-bit fractured TCAM. Turns single
// ternary rule writes and flushes into a full LUTRAM address sweep, keeping a
// shadow of all rules so the seven untouched rules of a group are rewritten
// unchanged. Outside sweeps the lookup key is forwarded to the TCAM.
// Ports:
//   wclk, rst_n         clock, async active-low reset
//   search_key          lookup key, forwarded to sk when idle
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_flush           request clears all rules
//   req_idx/value/mask/en  rule write payload (en=0 deletes)
//   done                one-cycle pulse at end of a sweep
//   sk, we, rules, clr  registered TCAM controls
module dblock_rule_writer
    import fractcam_pkg::*;
#(
    parameter int unsigned KW_SIZE = KW_SIZE_DEF,
    parameter int unsigned RD_SIZE = RD_SIZE_DEF
) (
    input  logic                       wclk,
    input  logic                       rst_n,
    input  logic [KW_SIZE-1:0]         search_key,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_flush,
    input  logic [$clog2(RD_SIZE)-1:0] req_idx,
    input  logic [KW_SIZE-1:0]         req_value,
    input  logic [KW_SIZE-1:0]         req_mask,
    input  logic                       req_en,
    output logic                       done,
    output logic [KW_SIZE-1:0]         sk,
    output logic [RD_SIZE/8-1:0]       we,
    output logic [7:0]                 rules,
    output logic                       clr
);

    localparam int unsigned WE_SIZE = RD_SIZE / GROUP_SIZE;
    localparam int unsigned IDX_W   = $clog2(RD_SIZE);
    localparam int unsigned GRP_W   = (IDX_W > 3) ? IDX_W - 3 : 1;
    localparam logic [KW_SIZE-1:0] ADDR_LAST = '1;

    // Shadow records are sized by the package key width.
    if (KW_SIZE != KW_SIZE_DEF) begin : g_kw_check
        $error("dblock_rule_writer: KW_SIZE must equal fractcam_pkg::KW_SIZE_DEF");
    end
    if ((RD_SIZE % GROUP_SIZE) != 0) begin : g_rd_check
        $error("dblock_rule_writer: RD_SIZE must be a multiple of 8");
    end

    state_t               state_q, state_d;
    logic [KW_SIZE-1:0]   addr_q, addr_d;
    logic                 flush_q, flush_d;
    logic [GRP_W-1:0]     grp_q, grp_d;
    logic [KW_SIZE-1:0]   sk_d;
    logic [WE_SIZE-1:0]   we_d;
    logic [7:0]           rules_d;
    logic                 clr_d;
    logic                 done_d;
    logic                 ready_d;
    logic                 accept_c;

    rule_entry_t                  shadow [RD_SIZE];
    rule_entry_t [GROUP_SIZE-1:0] grp_entries;
    logic [GROUP_SIZE-1:0]        eval_rules_c;

    // req_ready is only ever high in IDLE, so this implies IDLE.
    assign accept_c = req_valid && req_ready;

    // Shadow rule table, updated in the accept cycle.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_SIZE); i++) begin
                shadow[i] <= '0;
            end
        end else if (accept_c) begin
            if (req_flush) begin
                for (int i = 0; i < int'(RD_SIZE); i++) begin
                    shadow[i].valid <= 1'b0;
                end
            end else begin
                shadow[req_idx] <= '{valid: req_en, value: req_value, mask: req_mask};
            end
        end
    end

    // Select the eight shadow entries of the latched group.
    always_comb begin
        grp_entries = '0;
        for (int k = 0; k < int'(GROUP_SIZE); k++) begin
            grp_entries[k] = shadow[IDX_W'(int'(grp_q) * int'(GROUP_SIZE) + k)];
        end
    end

    dblock_rule_eval u_eval (
        .entries (grp_entries),
        .addr    (addr_q),
        .rules_c (eval_rules_c)
    );

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        flush_d = flush_q;
        grp_d   = grp_q;
        sk_d    = search_key;
        we_d    = '0;
        rules_d = '0;
        clr_d   = 1'b1;
        done_d  = 1'b0;
        ready_d = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                sk_d   = addr_q;
                we_d   = '1;
                addr_d = addr_q + KW_SIZE'(1);
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_IDLE: begin
                clr_d   = 1'b0;
                ready_d = !accept_c;
                if (accept_c) begin
                    flush_d = req_flush;
                    grp_d   = GRP_W'(req_idx >> 3);
                    addr_d  = '0;
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                sk_d = addr_q;
                if (flush_q) begin
                    we_d = '1;
                end else begin
                    we_d    = WE_SIZE'(1) << grp_q;
                    rules_d = eval_rules_c;
                end
                addr_d = addr_q + KW_SIZE'(1);
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep context and registered TCAM/handshake outputs.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            flush_q   <= 1'b0;
            grp_q     <= '0;
            sk        <= '0;
            we        <= '0;
            rules     <= '0;
            clr       <= 1'b1;
            done      <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            flush_q   <= flush_d;
            grp_q     <= grp_d;
            sk        <= sk_d;
            we        <= we_d;
            rules     <= rules_d;
            clr       <= clr_d;
            done      <= done_d;
            req_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_dblock_rule_writer.sv
// Scoreboard bench for dblock_rule_writer: stimulus pushes the hand-derived
// TCAM write/done events it expects, a negedge monitor pops and compares.
module tb_dblock_rule_writer;

    logic       wclk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] search_key;
    logic       req_valid;
    logic       req_ready;
    logic       req_flush;
    logic [4:0] req_idx;
    logic [4:0] req_value;
    logic [4:0] req_mask;
    logic       req_en;
    logic       done;
    logic [4:0] sk;
    logic [3:0] we;
    logic [7:0] rules;
    logic       clr;

    always #5 wclk = ~wclk;

    dblock_rule_writer dut (
        .wclk       (wclk),
        .rst_n      (rst_n),
        .search_key (search_key),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_flush  (req_flush),
        .req_idx    (req_idx),
        .req_value  (req_value),
        .req_mask   (req_mask),
        .req_en     (req_en),
        .done       (done),
        .sk         (sk),
        .we         (we),
        .rules      (rules),
        .clr        (clr)
    );

    typedef struct {
        logic [4:0] sk;
        logic [3:0] we;
        logic [7:0] rules;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every TCAM write or done pulse must match the next expectation.
    always @(negedge wclk) begin
        if (rst_n === 1'b1 && (we !== 4'h0 || done !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got sk=%0h we=%0h rules=%0h done=%0b expected none",
                         sk, we, rules, done);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.done) begin
                    check("done_event", {18'd0, we, rules, clr, done}, {18'd0, 4'h0, 8'h00, 1'b1, 1'b1});
                end else begin
                    check($sformatf("sweep_write_a%0d", e.sk), {13'd0, sk, we, rules, clr, done},
                          {13'd0, e.sk, e.we, e.rules, 1'b1, 1'b0});
                end
            end
        end
    end

    // Expected sweep: rules = sp_r at sp_addr, else r_lo below 16 / r_hi above.
    task automatic push_sweep(input logic [3:0] w, input logic [7:0] r_lo, input logic [7:0] r_hi,
                              input int sp_addr, input logic [7:0] sp_r, input int last);
        for (int a = 0; a <= last; a++) begin
            exp_t e;
            e.sk    = 5'(a);
            e.we    = w;
            e.rules = (a == sp_addr) ? sp_r : ((a < 16) ? r_lo : r_hi);
            e.done  = 1'b0;
            exp_q.push_back(e);
        end
        if (last == 31) begin
            exp_t d;
            d.sk    = 5'd0;
            d.we    = 4'h0;
            d.rules = 8'h00;
            d.done  = 1'b1;
            exp_q.push_back(d);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sk"}, 32'(sk), 32'd0);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_rules"}, 32'(rules), 32'd0);
        check({tag, "_clr"}, 32'(clr), 32'd1);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Count posedges until req_ready rises (sampled #1 after each edge).
    task automatic count_busy(input string name, input int exp_n);
        int n = 0;
        do begin
            @(posedge wclk);
            #1;
            n++;
        end while (req_ready !== 1'b1 && n < 100);
        check(name, 32'(n), 32'(exp_n));
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge wclk);
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge wclk);
            n++;
        end
        if (req_ready !== 1'b1) check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Issue one request at a negedge with ready high; checks first-write
    // latency and the busy window.
    task automatic issue(input string name, input logic fl, input logic [4:0] idx,
                         input logic [4:0] val, input logic [4:0] msk, input logic en);
        wait_ready();
        req_valid = 1'b1;
        req_flush = fl;
        req_idx   = idx;
        req_value = val;
        req_mask  = msk;
        req_en    = en;
        @(posedge wclk);
        #1;
        req_valid = 1'b0;
        check({name, "_ready_drop"}, 32'(req_ready), 32'd0);
        count_busy({name, "_busy"}, 34);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        search_key = 5'd3;
        req_valid  = 1'b0;
        req_flush  = 1'b0;
        req_idx    = '0;
        req_value  = '0;
        req_mask   = '0;
        req_en     = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset("reset");

        // INIT flush sweep after reset release.
        @(negedge wclk);
        @(negedge wclk);
        push_sweep(4'hF, 8'h00, 8'h00, -1, 8'h00, 31);
        rst_n = 1'b1;
        count_busy("init_busy", 34);
        check("idle_clr", 32'(clr), 32'd0);

        // Exact rule 3 = 10.
        push_sweep(4'h1, 8'h00, 8'h00, 10, 8'h08, 31);
        issue("exact", 1'b0, 5'd3, 5'h0A, 5'h00, 1'b1);

        // Search forwarding with one-cycle latency.
        @(negedge wclk);
        search_key = 5'd10;
        @(posedge wclk);
        #1;
        check("search_sk", 32'(sk), 32'd10);
        check("search_clr", 32'(clr), 32'd0);
        check("search_we", 32'(we), 32'd0);
        search_key = 5'd3;

        // Wildcard rule 9 then catch-all rule 8 in the same group.
        push_sweep(4'h2, 8'h00, 8'h02, -1, 8'h00, 31);
        issue("wild9", 1'b0, 5'd9, 5'h10, 5'h0F, 1'b1);
        push_sweep(4'h2, 8'h01, 8'h03, -1, 8'h00, 31);
        issue("wild8", 1'b0, 5'd8, 5'h00, 5'h1F, 1'b1);

        // Delete rule 9.
        push_sweep(4'h2, 8'h01, 8'h01, -1, 8'h00, 31);
        issue("delete9", 1'b0, 5'd9, 5'h10, 5'h0F, 1'b0);

        // Flush with a write to 31 held behind it.
        push_sweep(4'hF, 8'h00, 8'h00, -1, 8'h00, 31);
        push_sweep(4'h8, 8'h00, 8'h00, 31, 8'h80, 31);
        wait_ready();
        req_valid = 1'b1;
        req_flush = 1'b1;
        req_idx   = 5'd0;
        @(posedge wclk);
        #1;
        req_flush = 1'b0;
        req_idx   = 5'd31;
        req_value = 5'h1F;
        req_mask  = 5'h00;
        req_en    = 1'b1;
        count_busy("flush_busy", 34);
        @(posedge wclk);
        #1;
        req_valid = 1'b0;
        check("b2b_accept", 32'(req_ready), 32'd0);
        count_busy("b2b_busy", 34);

        // Reset in the middle of a sweep, at address 12.
        push_sweep(4'h1, 8'h08, 8'h08, -1, 8'h00, 12);
        wait_ready();
        req_valid = 1'b1;
        req_flush = 1'b0;
        req_idx   = 5'd3;
        req_value = 5'h00;
        req_mask  = 5'h1F;
        req_en    = 1'b1;
        @(posedge wclk);
        #1;
        req_valid = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge wclk);
                n++;
            end while (!(we === 4'h1 && sk === 5'd12) && n < 100);
        end
        check("abort_at_12", 32'(sk), 32'd12);
        #2 rst_n = 1'b0;
        #1 check_reset("abort_reset");
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        @(negedge wclk);
        @(negedge wclk);
        push_sweep(4'hF, 8'h00, 8'h00, -1, 8'h00, 31);
        rst_n = 1'b1;
        count_busy("reinit_busy", 34);

        // Old rule 3 must be gone: only rule 0 appears.
        push_sweep(4'h1, 8'h00, 8'h00, 0, 8'h01, 31);
        issue("post_reset", 1'b0, 5'd0, 5'h00, 5'h00, 1'b1);

        repeat (3) @(negedge wclk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dblock_rule_writer.md
# dblock_rule_writer

Update controller directly upstream of the 32-rule × 5-bit fractured TCAM block. It owns the TCAM's `sk`, `we`, `rules` and `clr` inputs. It converts single ternary rule writes (value/mask/valid) and flush commands into the 32-address LUTRAM sweep the TCAM requires. A shadow copy of all rules lets it regenerate the other seven rule bits of each 8-rule group. Outside sweeps it forwards the lookup key to the TCAM.

## Interface
Parameters:
- `KW_SIZE`, 5: key width; sweep length is 2^KW_SIZE.
- `RD_SIZE`, 32: number of rules; multiple of 8.
- `WE_SIZE`, RD_SIZE/8: derived; one write enable per 8-rule group.

Ports:
- `wclk`  in  1  clock; the TCAM is written on this same clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `search_key`  in  KW_SIZE  lookup key, forwarded when idle.
- `req_valid`  in  1  rule write request.
- `req_ready`  out  1  high only in IDLE.
- `req_flush`  in  1  qualifies `req_valid`: clear all rules (other req fields ignored).
- `req_idx`  in  log2(RD_SIZE)  target rule number.
- `req_value`  in  KW_SIZE  rule value.
- `req_mask`  in  KW_SIZE  1 = don't-care bit.
- `req_en`  in  1  rule valid; 0 deletes the rule.
- `done`  out  1  one-cycle pulse when a sweep finishes.
- `sk`  out  KW_SIZE  TCAM key/address (registered).
- `we`  out  WE_SIZE  TCAM group write enables (registered).
- `rules`  out  8  TCAM write data (registered).
- `clr`  out  1  TCAM match suppress (registered).

## Operation
- **Shadow state**
  - Per-rule `{valid, value, mask}` register array, RD_SIZE entries.
  - Rule j is set at address a iff `valid_j && ((a ^ value_j) & ~mask_j) == 0`.
- **States:** INIT, IDLE, SWEEP, DONE.
- **Reset**
  - All shadow valid bits clear.
  - FSM enters INIT with addr = 0.
- **INIT**
  - Flush sweep: each cycle `sk` = addr, `we` = all ones, `rules` = 0.
  - After addr = 2^KW−1, go to DONE.
  - Clears the LUTRAM contents left unknown by power-up.
- **IDLE**
  - `req_ready` = 1.
  - `sk` follows `search_key` with 1-cycle register delay; `we` = 0; `clr` = 0.
- **Accept** (`req_valid && req_ready`)
  - Write request: shadow[req_idx] updated in the accept cycle.
  - Flush: all shadow valids cleared in the accept cycle.
  - Latch group g = req_idx/8, or the flush flag; addr = 0; go to SWEEP.
- **SWEEP**
  - Each cycle register `sk` = addr.
  - Write: `we` = one-hot(g); `rules[k]` = rule bit of shadow entry 8g+k at addr.
  - Flush: `we` = all ones; `rules` = 0.
  - addr increments each cycle; after addr = 2^KW−1, go to DONE.
- **DONE**
  - `done` = 1 for one cycle; `we` = 0.
  - Next state IDLE.
- **`clr`:** 1 in INIT, SWEEP and DONE, so lookups are invalid during updates.
- **Back-to-back requests:** a request held high during a sweep is accepted in the first IDLE cycle.
- **Same-index rewrite:** rewriting the same req_idx simply overwrites the shadow entry.
- **Reset mid-sweep:** abort immediately; restart in INIT. Shadow contents are lost.

## Timing
- **Reset values:**
  - `sk` = 0, `we` = 0, `rules` = 0.
  - `clr` = 1 (INIT follows reset).
  - `req_ready` = 0, `done` = 0.
- **Accept to TCAM write:** accept at cycle T; first TCAM write (addr 0) is presented at T+1.
- **Sweep:** writes at addr 2^KW−1 occur at T+32 (KW = 5); `done` = 1 at T+33.
- **Ready:** `req_ready` = 1 again at T+34.
- **Busy window:** `req_ready` is low for 2^KW+1 cycles after acceptance.
- **After reset:**
  - INIT sweep occupies cycles 1..32 after `rst_n` release.
  - `done` at cycle 33; `req_ready` at cycle 34.
- **Search path:** 1-cycle latency from `search_key` to `sk` in IDLE.

## Structure
- **`fractcam_pkg`:**
  - Defaults for KW_SIZE and RD_SIZE.
  - FSM state encoding.
  - Shadow entry record type `{valid, value, mask}`.
- **Sub-module `dblock_rule_eval`:** combinational; takes 8 shadow entries plus an address and returns the 8-bit `rules` vector. Instantiated once, muxed by the latched group.

## Test plan
- **Reset/INIT:** release `rst_n` → `we` = 4'hF with `rules` = 0 on `sk` = 0..31 over 32 cycles; `done` pulse; then `req_ready` = 1.
- **Exact rule:** write idx 3, value 5'h0A, mask 0 → during the sweep `we` = 4'b0001; `rules` = 8'h08 only at `sk` = 10, else 0. After DONE, `search_key` = 10 drives `sk` = 10 one cycle later with `clr` = 0.
- **Wildcard and group sharing:**
  - Rule 9 = value 5'h10, mask 5'h0F; then rule 8 = value 0, mask 5'h1F.
  - Second sweep has `we` = 4'b0010.
  - `rules` = 8'h01 at `sk` = 0..15 and 8'h03 at `sk` = 16..31.
- **Delete:** rewrite rule 9 with `req_en` = 0 → the group-1 sweep gives `rules` = 8'h01 at all 32 addresses.
- **Flush and back-to-back:** issue a flush while `req_valid` is held for a write to idx 31 → flush sweep runs first; the write is accepted in the first IDLE cycle; its sweep has `we` = 4'b1000.
- **Reset mid-sweep:** assert `rst_n` = 0 at addr 12 → outputs take their reset values immediately; INIT sweep restarts at addr 0; old rules are absent afterwards.
